// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one serial transmitter between NUM_REQ byte-stream
// requesters with burst-granular round-robin arbitration, and owns the timing
// of the new_tx_data load strobe against tx_busy.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN (in-burst idle timeout with
// sticky timeout_err output and the TIMEOUT_CYCLES parameter).
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   new_tx_data,
    input  logic                   tx_busy,
    output logic                   busy
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    localparam int IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grantNext;
    logic [IdxW-1:0]      r_owner;
    logic [IdxW-1:0]      w_ownerNext;
    logic [IdxW-1:0]      r_ptr;
    logic [IdxW-1:0]      w_ptrNext;
    logic [7:0]           r_txData;
    logic [7:0]           w_txDataNext;
    logic                 r_strobe;
    logic                 w_strobeNext;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   w_ackNext;
    logic                 r_last;
    logic                 w_lastNext;

    logic                 w_pickFound;
    logic [IdxW-1:0]      w_pickIdx;
    logic [IdxW:0]        w_cand;

    logic                 w_ownerReq;
    logic                 w_ownerValid;
    logic                 w_ownerLast;
    logic [7:0]           w_ownerData;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0]      r_idleCnt;
    logic [CntW-1:0]      w_idleCntNext;
    logic                 r_timeoutErr;
    logic                 w_timeoutErrNext;
`endif

    // The owner index selects the granted requester's lane of every input bus.
    assign w_ownerReq   = req[r_owner];
    assign w_ownerValid = req_valid[r_owner];
    assign w_ownerLast  = req_last[r_owner];
    assign w_ownerData  = req_data[{r_owner, 3'b000} +: 8];

    // Round-robin pick: first requesting index at or above the pointer, wrapping.
    always_comb begin
        w_pickFound = 1'b0;
        w_pickIdx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IdxW + 1)'(k);
            if (w_cand >= (IdxW + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (IdxW + 1)'(NUM_REQ);
            end
            if (!w_pickFound && req[w_cand[IdxW-1:0]]) begin
                w_pickFound = 1'b1;
                w_pickIdx   = w_cand[IdxW-1:0];
            end
        end
    end

    // Next-state and next-register logic; strobe and ack default low so they pulse.
    always_comb begin
        w_stateNext  = r_state;
        w_grantNext  = r_grant;
        w_ownerNext  = r_owner;
        w_ptrNext    = r_ptr;
        w_txDataNext = r_txData;
        w_strobeNext = 1'b0;
        w_ackNext    = '0;
        w_lastNext   = r_last;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_idleCntNext    = r_idleCnt;
        w_timeoutErrNext = r_timeoutErr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pickFound) begin
                    w_grantNext = NUM_REQ'(1) << w_pickIdx;
                    w_ownerNext = w_pickIdx;
                    w_stateNext = ST_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    w_idleCntNext = '0;
`endif
                end
            end
            ST_SEND: begin
                if (!w_ownerReq) begin
                    w_stateNext = ST_RELEASE;
                end else if (w_ownerValid && !tx_busy) begin
                    w_txDataNext = w_ownerData;
                    w_strobeNext = 1'b1;
                    w_ackNext    = NUM_REQ'(1) << r_owner;
                    w_lastNext   = w_ownerLast;
                    w_stateNext  = ST_HOLD;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    w_idleCntNext = '0;
`endif
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (!w_ownerValid) begin
                    if (r_idleCnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        w_stateNext      = ST_RELEASE;
                        w_timeoutErrNext = 1'b1;
                    end else begin
                        w_idleCntNext = r_idleCnt + 1'b1;
                    end
                end
`endif
            end
            ST_HOLD: begin
                w_stateNext = r_last ? ST_RELEASE : ST_SEND;
            end
            ST_RELEASE: begin
                w_grantNext = '0;
                w_ptrNext   = (r_owner == LastIdx) ? '0 : r_owner + 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Grant, pointer and transmitter-side output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant  <= '0;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_txData <= 8'h00;
            r_strobe <= 1'b0;
            r_ack    <= '0;
            r_last   <= 1'b0;
        end else begin
            r_grant  <= w_grantNext;
            r_owner  <= w_ownerNext;
            r_ptr    <= w_ptrNext;
            r_txData <= w_txDataNext;
            r_strobe <= w_strobeNext;
            r_ack    <= w_ackNext;
            r_last   <= w_lastNext;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Idle-in-burst counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idleCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_idleCnt    <= w_idleCntNext;
            r_timeoutErr <= w_timeoutErrNext;
        end
    end

    assign timeout_err = r_timeoutErr;
`endif

    assign grant       = r_grant;
    assign req_ack     = r_ack;
    assign tx_data     = r_txData;
    assign new_tx_data = r_strobe;
    assign busy        = |r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for burst, contention, backpressure,
// requester drop and asynchronous reset, followed by a randomized phase that
// checks the arbiter against a burst-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N = 3;

    logic             clock = 1'b0;
    logic             resetN;
    logic [N-1:0]     req;
    logic [8*N-1:0]   reqData;
    logic [N-1:0]     reqValid;
    logic [N-1:0]     reqLast;
    logic [N-1:0]     reqAck;
    logic [N-1:0]     grant;
    logic [7:0]       txData;
    logic             newTxData;
    logic             txBusy;
    logic             busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic             timeoutErr;
`endif

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Contention scenario expectations, one entry per cycle after req rises.
    logic [N-1:0] cGrant  [9];
    logic         cStrobe [9];
    logic [7:0]   cData   [9];

    // Randomized-phase streams and reference-model state.
    logic [7:0]   streamData [N][16];
    bit           streamLast [N][16];
    int           streamLen  [N];
    int           drvHead    [N];
    int           sbHead     [N];
    int           modelOwner;
    int           modelPtr;
    int           releaseAt;
    int           lastStrobe;
    int           busyLeft;
    logic [7:0]   lastTx;
    logic [N-1:0] reqPrev;
    logic [N-1:0] expGrant;
    logic [N-1:0] expAck;
    logic         prevTxBusy;
    logic         strobeSeen;
    logic         ackSeen;
    int           strobeCycle;
    int           remaining;
    bit           done;

    uart_tx_arbiter #(
        .NUM_REQ(N)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clock),
        .rst(resetN),
        .req(req),
        .req_data(reqData),
        .req_valid(reqValid),
        .req_last(reqLast),
        .req_ack(reqAck),
        .grant(grant),
        .tx_data(txData),
        .new_tx_data(newTxData),
        .tx_busy(txBusy),
        .busy(busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeoutErr)
`endif
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic [8*N-1:0] d, input logic b);
        req      = r;
        reqValid = v;
        reqLast  = l;
        reqData  = d;
        txBusy   = b;
    endtask

    task automatic doReset();
        applyStimulus('0, '0, '0, '0, 1'b0);
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    function automatic int pickNext(input logic [N-1:0] r, input int ptr);
        int result = -1;
        for (int k = 0; k < N; k++) begin
            int idx = (ptr + k) % N;
            if (result < 0 && r[idx]) result = idx;
        end
        return result;
    endfunction

    // Overall time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus and checking sequence.
    initial begin
        resetN = 1'b0;
        applyStimulus('0, '0, '0, '0, 1'b0);

        // Reset values.
        doReset();
        checkOutput("reset.grant", grant, 0);
        checkOutput("reset.ack", reqAck, 0);
        checkOutput("reset.strobe", newTxData, 0);
        checkOutput("reset.txData", txData, 8'h00);
        checkOutput("reset.busy", busy, 0);

        // Single two-byte burst from requester 0.
        applyStimulus(3'b001, 3'b001, 3'b000, {16'h0, 8'h48}, 1'b0);
        tick();
        checkOutput("burst.grant", grant, 3'b001);
        checkOutput("burst.noEarlyStrobe", newTxData, 0);
        tick();
        checkOutput("burst.strobe1", newTxData, 1);
        checkOutput("burst.byte1", txData, 8'h48);
        checkOutput("burst.ack1", reqAck, 3'b001);
        strobeCycle = cycle;
        applyStimulus(3'b001, 3'b001, 3'b001, {16'h0, 8'h69}, 1'b0);
        tick();
        checkOutput("burst.gap", newTxData, 0);
        checkOutput("burst.holdData", txData, 8'h48);
        tick();
        checkOutput("burst.strobe2", newTxData, 1);
        checkOutput("burst.byte2", txData, 8'h69);
        checkOutput("burst.ack2", reqAck, 3'b001);
        checkOutput("burst.spacing", cycle - strobeCycle, 2);
        applyStimulus('0, '0, '0, '0, 1'b0);
        tick();
        checkOutput("burst.releaseGrant", grant, 3'b001);
        tick();
        checkOutput("burst.idleGrant", grant, 0);
        checkOutput("burst.idleBusy", busy, 0);

        // Contention: requesters 0 and 1 request together, one byte per burst.
        cGrant  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001};
        cStrobe = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        cData   = '{8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
        doReset();
        applyStimulus(3'b011, 3'b011, 3'b011, {8'h0, 8'hB1, 8'hA0}, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tick();
            checkOutput($sformatf("contend.grant%0d", k), grant, cGrant[k]);
            checkOutput($sformatf("contend.strobe%0d", k), newTxData, cStrobe[k]);
            checkOutput($sformatf("contend.data%0d", k), txData, cData[k]);
        end

        // Backpressure: transmitter busy for 20 cycles after the first strobe.
        doReset();
        applyStimulus(3'b001, 3'b001, 3'b000, {16'h0, 8'h11}, 1'b0);
        tick();
        tick();
        checkOutput("bp.strobe1", newTxData, 1);
        checkOutput("bp.byte1", txData, 8'h11);
        applyStimulus(3'b001, 3'b001, 3'b001, {16'h0, 8'h22}, 1'b1);
        strobeSeen = 1'b0;
        ackSeen    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            strobeSeen = strobeSeen | newTxData;
            ackSeen    = ackSeen | (|reqAck);
        end
        checkOutput("bp.noStrobeWhileBusy", strobeSeen, 0);
        checkOutput("bp.noAckWhileBusy", ackSeen, 0);
        txBusy = 1'b0;
        tick();
        checkOutput("bp.strobe2", newTxData, 1);
        checkOutput("bp.byte2", txData, 8'h22);
        checkOutput("bp.ack2", reqAck, 3'b001);

        // Requester 1 drops req mid-burst without sending; requester 0 follows.
        doReset();
        applyStimulus(3'b010, 3'b000, 3'b000, '0, 1'b0);
        tick();
        checkOutput("drop.grant1", grant, 3'b010);
        tick();
        tick();
        applyStimulus(3'b001, 3'b000, 3'b000, '0, 1'b0);
        strobeSeen = 1'b0;
        tick();
        checkOutput("drop.releaseGrant", grant, 3'b010);
        strobeSeen = strobeSeen | newTxData;
        tick();
        checkOutput("drop.idleGrant", grant, 0);
        strobeSeen = strobeSeen | newTxData;
        tick();
        checkOutput("drop.nextGrant", grant, 3'b001);
        strobeSeen = strobeSeen | newTxData;
        checkOutput("drop.noStrobe", strobeSeen, 0);

        // Asynchronous reset while the arbiter holds after a strobe.
        doReset();
        applyStimulus(3'b001, 3'b001, 3'b001, {16'h0, 8'h5A}, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(3'b011, 3'b011, 3'b000, {8'h0, 8'hC2, 8'hC1}, 1'b0);
        tick();
        checkOutput("areset.idle", grant, 0);
        tick();
        checkOutput("areset.rrGrant", grant, 3'b010);
        tick();
        checkOutput("areset.strobe", newTxData, 1);
        checkOutput("areset.byte", txData, 8'hC2);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("areset.grantNow", grant, 0);
        checkOutput("areset.strobeNow", newTxData, 0);
        checkOutput("areset.ackNow", reqAck, 0);
        checkOutput("areset.busyNow", busy, 0);
        checkOutput("areset.txDataNow", txData, 8'h00);
        #1;
        resetN = 1'b1;
        tick();
        checkOutput("areset.priority0", grant, 3'b001);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Timeout: granted requester never presents a byte.
        doReset();
        applyStimulus(3'b001, 3'b000, 3'b000, '0, 1'b0);
        for (int k = 0; k < 16; k++) tick();
        checkOutput("timeout.stillGranted", grant, 3'b001);
        checkOutput("timeout.errLow", timeoutErr, 0);
        tick();
        checkOutput("timeout.errSet", timeoutErr, 1);
        tick();
        checkOutput("timeout.released", grant, 0);
        applyStimulus('0, '0, '0, '0, 1'b0);
        tick();
        checkOutput("timeout.sticky", timeoutErr, 1);
`endif

        // Randomized phase: several bursts per requester, random valid gaps and busy times.
        doReset();
        for (int i = 0; i < N; i++) begin
            streamLen[i] = 0;
            drvHead[i]   = 0;
            sbHead[i]    = 0;
            for (int b = 0; b < 3; b++) begin
                int n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) begin
                    streamData[i][streamLen[i]] = 8'($urandom);
                    streamLast[i][streamLen[i]] = (j == n - 1);
                    streamLen[i]++;
                end
            end
        end
        modelOwner = -1;
        modelPtr   = 0;
        releaseAt  = -1;
        lastStrobe = -10;
        busyLeft   = 0;
        lastTx     = 8'h00;
        done       = 1'b0;

        for (int it = 0; it < 4000 && !done; it++) begin
            reqPrev    = req;
            prevTxBusy = txBusy;
            tick();

            // Reference model: who should own the transmitter this cycle.
            if (modelOwner < 0) begin
                if (reqPrev != '0) begin
                    modelOwner = pickNext(reqPrev, modelPtr);
                    expGrant   = N'(1) << modelOwner;
                end else begin
                    expGrant = '0;
                end
            end else if (cycle == releaseAt) begin
                expGrant   = '0;
                modelPtr   = (modelOwner + 1) % N;
                modelOwner = -1;
            end else begin
                expGrant = N'(1) << modelOwner;
            end
            checkOutput("rnd.grant", grant, expGrant);
            checkOutput("rnd.busy", busy, |expGrant);

            // Scoreboard: every strobe carries the owner's next byte.
            if (newTxData) begin
                expAck = (modelOwner >= 0) ? N'(1) << modelOwner : '0;
                checkOutput("rnd.ack", reqAck, expAck);
                checkOutput("rnd.strobeWhileBusy", prevTxBusy, 0);
                checkOutput("rnd.strobeSpacing", (cycle - lastStrobe) >= 2, 1);
                lastStrobe = cycle;
                if (modelOwner >= 0 && sbHead[modelOwner] < streamLen[modelOwner]) begin
                    checkOutput("rnd.data", txData, streamData[modelOwner][sbHead[modelOwner]]);
                    lastTx = streamData[modelOwner][sbHead[modelOwner]];
                    if (streamLast[modelOwner][sbHead[modelOwner]]) releaseAt = cycle + 2;
                    sbHead[modelOwner]++;
                end else begin
                    checkOutput("rnd.unexpectedStrobe", newTxData, 0);
                end
            end else begin
                checkOutput("rnd.noAck", reqAck, 0);
                checkOutput("rnd.txHold", txData, lastTx);
            end

            // Requester behaviour.
            for (int i = 0; i < N; i++) begin
                if (reqAck[i] && drvHead[i] < streamLen[i]) begin
                    if (streamLast[i][drvHead[i]]) req[i] = 1'b0;
                    drvHead[i]++;
                end
                if (!req[i] && drvHead[i] < streamLen[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
                if (drvHead[i] < streamLen[i]) begin
                    reqValid[i]          = ($urandom_range(0, 3) != 0);
                    reqData[8*i +: 8]    = streamData[i][drvHead[i]];
                    reqLast[i]           = streamLast[i][drvHead[i]];
                end else begin
                    reqValid[i]          = 1'b0;
                    reqData[8*i +: 8]    = 8'($urandom);
                    reqLast[i]           = 1'($urandom);
                end
            end

            // Transmitter behaviour: random busy time after each load.
            if (newTxData) busyLeft = $urandom_range(0, 4);
            else if (busyLeft > 0) busyLeft--;
            txBusy = (busyLeft > 0);

            done = 1'b1;
            for (int i = 0; i < N; i++) if (drvHead[i] < streamLen[i]) done = 1'b0;
            if (modelOwner >= 0 || cycle <= releaseAt) done = 1'b0;
        end

        remaining = 0;
        for (int i = 0; i < N; i++) remaining += streamLen[i] - sbHead[i];
        checkOutput("rnd.finished", done, 1);
        checkOutput("rnd.drained", remaining, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
